// File: rtl/carp_fetch_pkg.sv
// Shared defaults and state encoding for the CARP instruction fetch unit.
package carp_fetch_pkg;

  localparam int unsigned ADDR_W_DEF   = 16;
  localparam int unsigned INSTR_W_DEF  = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/carp_fetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO with synchronous flush and occupancy count.
module carp_fetch_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic [PTR_W:0]   count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/carp_fetch.sv
// Instruction fetch: issues sequential program-memory reads into a prefetch
// buffer, handles redirects (flushing stale reads) and halt/drain.
module carp_fetch
  import carp_fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = ADDR_W_DEF,
  parameter int unsigned        INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned        DEPTH    = 2
) (
  input  logic               CLK,
  input  logic               RST,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               dec_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               halted
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned OCC_W   = CNT_W + 1;
  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

  fetch_state_t       state;
  fetch_state_t       state_nxt;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_nxt;
  logic [ADDR_W-1:0]  rsp_pc;
  logic               inflight;
  logic               issue;
  logic               flush;
  logic               pop;
  logic               push;
  logic               space;
  logic [OCC_W-1:0]   occ;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head;

  assign pop   = if_valid & dec_ready;
  assign occ   = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
  assign space = occ < OCC_W'(DEPTH);
  // A response landing in FLUSH belongs to the pre-redirect stream.
  assign push  = inflight & (state != FLUSH);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= RUN;
      pc       <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      inflight <= issue;
    end
  end

  always_ff @(posedge CLK) begin
    if (issue) rsp_pc <= pc;
  end

  // Issue decision does not wait on redirect; a read issued in the redirect
  // cycle is dropped by the following FLUSH cycle.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    issue     = 1'b0;
    flush     = 1'b0;
    unique case (state)
      RUN: begin
        issue = space & (redirect_valid | ~halt_req);
        if (redirect_valid) begin
          flush     = 1'b1;
          pc_nxt    = redirect_pc;
          state_nxt = issue ? FLUSH : RUN;
        end else begin
          if (issue)    pc_nxt    = pc + ADDR_W'(1);
          if (halt_req) state_nxt = HALT;
        end
      end
      FLUSH: begin
        issue = 1'b1;
        if (redirect_valid) begin
          flush     = 1'b1;
          pc_nxt    = redirect_pc;
          state_nxt = FLUSH;
        end else begin
          pc_nxt    = pc + ADDR_W'(1);
          state_nxt = RUN;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          flush     = 1'b1;
          pc_nxt    = redirect_pc;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  carp_fetch_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .flush (flush),
    .push  (push),
    .wdata ({rsp_pc, imem_rdata}),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  assign imem_en   = RST & issue;
  assign imem_addr = pc;
  assign if_valid  = (count != '0);
  assign if_pc     = head[ENTRY_W-1:INSTR_W];
  assign if_instr  = head[INSTR_W-1:0];
  assign halted    = (state == HALT) & (count == '0) & ~inflight;

endmodule

// File: tb/tb_carp_fetch.sv
// Directed, table-driven bench for carp_fetch with a ROM[i] = i + 16'h1000 memory model.
module tb_carp_fetch;

  logic        CLK;
  logic        RST;
  logic        dec_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt_req;

  logic        imem_en,  w_imem_en;
  logic [15:0] imem_addr, w_imem_addr;
  logic [15:0] imem_rdata, w_imem_rdata;
  logic        if_valid, w_if_valid;
  logic [15:0] if_instr, w_if_instr;
  logic [15:0] if_pc, w_if_pc;
  logic        halted, w_halted;
  logic        w_redirect_valid;
  logic [15:0] w_redirect_pc;
  logic        w_halt_req;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [15:0] rpc;
    logic        halt;
    logic        en;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] ipc;
    logic        hlt;
  } vec_t;

  vec_t vecs[$];

  carp_fetch #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .DEPTH(2)) u_dut (
    .CLK            (CLK),
    .RST            (RST),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .dec_ready      (dec_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halted         (halted)
  );

  carp_fetch #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'hFFFE), .DEPTH(2)) u_wrap (
    .CLK            (CLK),
    .RST            (RST),
    .imem_en        (w_imem_en),
    .imem_addr      (w_imem_addr),
    .imem_rdata     (w_imem_rdata),
    .if_valid       (w_if_valid),
    .if_instr       (w_if_instr),
    .if_pc          (w_if_pc),
    .dec_ready      (dec_ready),
    .redirect_valid (w_redirect_valid),
    .redirect_pc    (w_redirect_pc),
    .halt_req       (w_halt_req),
    .halted         (w_halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous ROM; garbage when not read so stray writes are visible.
  always @(posedge CLK) begin
    imem_rdata   <= imem_en   ? imem_addr   + 16'h1000 : 16'hDEAD;
    w_imem_rdata <= w_imem_en ? w_imem_addr + 16'h1000 : 16'hDEAD;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic rdy, input logic rv, input logic [15:0] rpc,
                     input logic halt, input logic en, input logic [15:0] addr,
                     input logic vld, input logic [15:0] ipc, input logic hlt);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.halt = halt;
    v.en = en; v.addr = addr; v.vld = vld; v.ipc = ipc; v.hlt = hlt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic rv,
                       input logic [15:0] rpc, input logic halt);
    @(negedge CLK);
    RST = rst; dec_ready = rdy; redirect_valid = rv; redirect_pc = rpc; halt_req = halt;
    #1;
  endtask

  initial begin
    RST = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
    w_redirect_valid = 1'b0; w_redirect_pc = '0; w_halt_req = 1'b0;

    // rst rdy rv rpc halt | en addr vld ipc halted
    add(1,1,0,16'h0000,0, 1,16'h0000, 0,16'h0000, 0);
    add(1,1,0,16'h0000,0, 1,16'h0001, 0,16'h0000, 0);
    add(1,1,0,16'h0000,0, 1,16'h0002, 1,16'h0000, 0);
    add(1,1,0,16'h0000,0, 1,16'h0003, 1,16'h0001, 0);
    add(1,1,0,16'h0000,0, 1,16'h0004, 1,16'h0002, 0);
    for (int k = 0; k < 10; k++)
      add(1,0,0,16'h0000,0, 0,16'h0000, 1,16'h0003, 0);
    add(1,1,0,16'h0000,0, 1,16'h0005, 1,16'h0003, 0);
    add(1,1,0,16'h0000,0, 1,16'h0006, 1,16'h0004, 0);
    add(1,1,0,16'h0000,0, 1,16'h0007, 1,16'h0005, 0);
    add(1,1,1,16'h0040,0, 1,16'h0008, 1,16'h0006, 0);
    add(1,1,0,16'h0000,0, 1,16'h0040, 0,16'h0000, 0);
    add(1,1,0,16'h0000,0, 1,16'h0041, 0,16'h0000, 0);
    add(1,1,0,16'h0000,0, 1,16'h0042, 1,16'h0040, 0);
    add(1,1,0,16'h0000,0, 1,16'h0043, 1,16'h0041, 0);
    add(1,1,0,16'h0000,1, 0,16'h0000, 1,16'h0042, 0);
    add(1,1,0,16'h0000,0, 0,16'h0000, 1,16'h0043, 0);
    add(1,1,0,16'h0000,0, 0,16'h0000, 0,16'h0000, 1);
    add(1,1,0,16'h0000,0, 0,16'h0000, 0,16'h0000, 1);
    add(1,1,1,16'h0010,0, 0,16'h0000, 0,16'h0000, 1);
    add(1,1,0,16'h0000,0, 1,16'h0010, 0,16'h0000, 0);
    add(1,1,0,16'h0000,0, 1,16'h0011, 0,16'h0000, 0);
    add(1,1,0,16'h0000,0, 1,16'h0012, 1,16'h0010, 0);
    add(1,1,0,16'h0000,0, 1,16'h0013, 1,16'h0011, 0);
    add(1,1,1,16'h0020,1, 1,16'h0014, 1,16'h0012, 0);
    add(1,1,0,16'h0000,0, 1,16'h0020, 0,16'h0000, 0);
    add(1,1,0,16'h0000,0, 1,16'h0021, 0,16'h0000, 0);
    add(1,1,0,16'h0000,0, 1,16'h0022, 1,16'h0020, 0);

    // Reset state
    drive(0,0,0,16'h0000,0);
    chk("rst if_valid", 32'(if_valid), 32'd0);
    chk("rst halted",   32'(halted),   32'd0);
    chk("rst imem_en",  32'(imem_en),  32'd0);
    drive(0,0,0,16'h0000,0);
    chk("rst2 imem_en", 32'(imem_en),  32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rpc, vecs[i].halt);
      chk($sformatf("row%0d imem_en", i), 32'(imem_en), 32'(vecs[i].en));
      if (vecs[i].en)
        chk($sformatf("row%0d imem_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
      chk($sformatf("row%0d if_valid", i), 32'(if_valid), 32'(vecs[i].vld));
      if (vecs[i].vld) begin
        chk($sformatf("row%0d if_pc", i), 32'(if_pc), 32'(vecs[i].ipc));
        chk($sformatf("row%0d if_instr", i), 32'(if_instr), 32'(16'(vecs[i].ipc + 16'h1000)));
      end
      chk($sformatf("row%0d halted", i), 32'(halted), 32'(vecs[i].hlt));
      if (i >= 2 && i <= 5) begin
        chk($sformatf("wrap row%0d if_valid", i), 32'(w_if_valid), 32'd1);
        chk($sformatf("wrap row%0d if_pc", i), 32'(w_if_pc), 32'(16'(16'hFFFE + 16'(i - 2))));
        chk($sformatf("wrap row%0d if_instr", i), 32'(w_if_instr),
            32'(16'(16'hFFFE + 16'(i - 2) + 16'h1000)));
      end
    end

    // Fill the buffer, then reset mid-operation
    drive(1,0,0,16'h0000,0);
    chk("fill1 imem_en", 32'(imem_en), 32'd0);
    drive(1,0,0,16'h0000,0);
    chk("fill2 if_pc", 32'(if_pc), 32'h0021);
    drive(1,0,0,16'h0000,0);
    chk("full if_valid", 32'(if_valid), 32'd1);
    chk("full imem_en",  32'(imem_en),  32'd0);
    drive(0,0,0,16'h0000,0);
    chk("midrst imem_en", 32'(imem_en), 32'd0);
    drive(1,1,0,16'h0000,0);
    chk("postrst if_valid",  32'(if_valid),  32'd0);
    chk("postrst halted",    32'(halted),    32'd0);
    chk("postrst imem_en",   32'(imem_en),   32'd1);
    chk("postrst imem_addr", 32'(imem_addr), 32'h0000);
    chk("postrst wrap addr", 32'(w_imem_addr), 32'hFFFE);
    drive(1,1,0,16'h0000,0);
    chk("postrst+1 if_valid",  32'(if_valid),  32'd0);
    chk("postrst+1 imem_addr", 32'(imem_addr), 32'h0001);
    drive(1,1,0,16'h0000,0);
    chk("postrst+2 if_valid", 32'(if_valid), 32'd1);
    chk("postrst+2 if_pc",    32'(if_pc),    32'h0000);
    chk("postrst+2 if_instr", 32'(if_instr), 32'h1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
